// File: rtl/bnn_mlp_pkg.sv
// Shared types and elaboration helpers for the time-multiplexed binarized MLP layer.
package bnn_mlp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CMP,
        DONE
    } state_t;

    localparam int MAX_CHUNK = 256;

    function automatic int thr_width(input int input_size);
        return $clog2(input_size + 1);
    endfunction

    function automatic int nchunk(input int input_size, input int chunk);
        return (input_size + chunk - 1) / chunk;
    endfunction

    // Ones for the bit positions of the final chunk that map onto real input bits.
    function automatic logic [MAX_CHUNK-1:0] last_chunk_mask(input int input_size, input int chunk);
        logic [MAX_CHUNK-1:0] m;
        int rem;
        rem = input_size - (nchunk(input_size, chunk) - 1) * chunk;
        m = '0;
        for (int k = 0; k < MAX_CHUNK; k++) begin
            m[k] = (k < rem);
        end
        return m;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational CHUNK-wide masked XNOR popcount: counts positions where a and b agree under mask.
module bnn_xnor_popcount #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0]             a,
    input  logic [CHUNK-1:0]             b,
    input  logic [CHUNK-1:0]             mask,
    output logic [$clog2(CHUNK+1)-1:0]   count
);
    localparam int CW = $clog2(CHUNK + 1);

    logic [CHUNK-1:0] match;

    always_comb begin
        match = ~(a ^ b) & mask;
        count = '0;
        for (int k = 0; k < CHUNK; k++) begin
            count = count + CW'(match[k]);
        end
    end

endmodule

// File: rtl/mlp_layer_seq.sv
// Sequential binarized MLP layer: one XNOR-popcount unit shared by all neurons, weights streamed per chunk.
// Optional debug/argmax score ports are enabled by defining MLP_SEQ_SCORE_EN.
module mlp_layer_seq
    import bnn_mlp_pkg::*;
#(
    parameter int  INPUT_SIZE      = 288,
    parameter int  OUTPUT_SIZE     = 8,
    parameter int  CHUNK           = 32,
    localparam int THRESHOLD_WIDTH = thr_width(INPUT_SIZE),
    localparam int NCHUNK          = nchunk(INPUT_SIZE, CHUNK),
    localparam int AW              = $clog2(OUTPUT_SIZE * NCHUNK)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [INPUT_SIZE-1:0]                  in_vec,
    input  logic [OUTPUT_SIZE*THRESHOLD_WIDTH-1:0] threshold,
    output logic                                   w_req,
    output logic [AW-1:0]                          w_addr,
    input  logic                                   w_valid,
    input  logic [CHUNK-1:0]                       w_data,
    output logic                                   busy,
    output logic                                   done,
    output logic [OUTPUT_SIZE-1:0]                 out
`ifdef MLP_SEQ_SCORE_EN
    ,
    output logic                                   score_valid,
    output logic [$clog2(OUTPUT_SIZE)-1:0]         score_idx,
    output logic [THRESHOLD_WIDTH-1:0]             score
`endif
);
    localparam int CW   = $clog2(CHUNK + 1);
    localparam int CHW  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NW   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PADW = NCHUNK * CHUNK;
    localparam logic [MAX_CHUNK-1:0] LAST_FULL = last_chunk_mask(INPUT_SIZE, CHUNK);
    localparam logic [CHUNK-1:0]     LAST_MASK = LAST_FULL[CHUNK-1:0];

    state_t                     state, state_next;
    logic [CHW-1:0]             chunk_cnt;
    logic [NW-1:0]              neuron_cnt;
    logic [THRESHOLD_WIDTH-1:0] acc;
    logic [THRESHOLD_WIDTH-1:0] thr_cur;
    logic [AW-1:0]              addr;
    logic [PADW-1:0]            in_reg;
    logic [OUTPUT_SIZE-1:0]     shadow;
    logic [CHUNK-1:0]           in_chunk;
    logic [CHUNK-1:0]           mask;
    logic [CW-1:0]              chunk_count;
    logic                       last_chunk;
    logic                       last_neuron;

    assign last_chunk  = (chunk_cnt == CHW'(NCHUNK - 1));
    assign last_neuron = (neuron_cnt == NW'(OUTPUT_SIZE - 1));
    assign in_chunk    = in_reg[int'(chunk_cnt)*CHUNK +: CHUNK];
    assign mask        = last_chunk ? LAST_MASK : '1;
    assign thr_cur     = threshold[int'(neuron_cnt)*THRESHOLD_WIDTH +: THRESHOLD_WIDTH];

    // Requests are issued neuron-major, chunk-minor, so a linear counter equals neuron*NCHUNK+chunk.
    assign w_addr = addr;
    assign busy   = (state != IDLE) || done;

    bnn_xnor_popcount #(
        .CHUNK (CHUNK)
    ) u_popcount (
        .a     (w_data),
        .b     (in_chunk),
        .mask  (mask),
        .count (chunk_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        w_req      = 1'b0;
        unique case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
                w_req      = 1'b1;
                state_next = WAIT;
            end
            WAIT: if (w_valid) state_next = last_chunk ? CMP : REQ;
            CMP:  state_next = last_neuron ? DONE : REQ;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chunk_cnt  <= '0;
            neuron_cnt <= '0;
            acc        <= '0;
            addr       <= '0;
            out        <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    chunk_cnt  <= '0;
                    neuron_cnt <= '0;
                    acc        <= '0;
                    addr       <= '0;
                end
                WAIT: if (w_valid) begin
                    // acc never exceeds INPUT_SIZE, so THRESHOLD_WIDTH bits cannot overflow.
                    acc  <= acc + THRESHOLD_WIDTH'(chunk_count);
                    addr <= addr + AW'(1);
                    if (!last_chunk) chunk_cnt <= chunk_cnt + CHW'(1);
                end
                CMP: begin
                    acc       <= '0;
                    chunk_cnt <= '0;
                    if (!last_neuron) neuron_cnt <= neuron_cnt + NW'(1);
                end
                DONE: begin
                    out  <= shadow;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Activation latch and per-neuron result shadow are pure data; out is only loaded from shadow in DONE.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) in_reg <= PADW'(in_vec);
        if (state == CMP) shadow[neuron_cnt] <= (acc >= thr_cur);
    end

`ifdef MLP_SEQ_SCORE_EN
    assign score_valid = (state == CMP);
    assign score_idx   = neuron_cnt;
    assign score       = acc;
`endif

endmodule
